branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised next-PC predictor for the IF stage of the 5-stage pipelined core.
- Provides a direct-mapped branch target buffer (BTB) plus a pattern history table (PHT) of 2-bit saturating counters.
- Predicts the next PC for conditional branches, JAL and JALR from the current fetch PC.
- Trained non-speculatively by the EX stage when a control instruction resolves.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 32, BTB and PHT depth; power of 2, at least 2.
- GHR_BITS, 5, global history length; must be at most log2(ENTRIES). Only used with GSHARE_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- if_pc  in  XLEN  current fetch PC.
- pred_taken  out  1  predict redirect.
- pred_target  out  XLEN  BTB target for if_pc; 0 on miss.
- pred_next_pc  out  XLEN  predicted next fetch PC.
- update_valid  in  1  resolved control instruction this cycle.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_is_cond  in  1  1 = conditional branch; 0 = JAL/JALR.
- update_taken  in  1  actual direction.
- update_target  in  XLEN  actual target.

Interface: reset is synchronous and active-high (reset); clock is clk. All state updates on posedge clk.

Behaviour:
- Address split, with IDX = log2(ENTRIES):
  - idx = pc[IDX+1:2]
  - tag = pc[XLEN-1:IDX+2]
  - pc[1:0] ignored.
- BTB entry fields: valid, tag, target[XLEN-1:0], is_cond.
- PHT entry: 2-bit counter. Encoding 0 = SNT, 1 = WNT, 2 = WT, 3 = ST.
- PHT index p_idx:
  - With GSHARE_EN: idx XOR zero-extended ghr.
  - Without GSHARE_EN: idx.
- Prediction (combinational, zero latency, from registered state):
  - hit = valid[idx] && tag[idx] == tag(if_pc).
  - pred_taken = !reset && hit && (!is_cond[idx] || pht[p_idx][1]).
  - pred_target = hit ? target[idx] : 0.
  - pred_next_pc = pred_taken ? pred_target : if_pc + 4 (mod 2^XLEN; 0xFFFFFFFC wraps to 0).
- Update, on posedge when update_valid:
  - If update_taken: write BTB[idx(update_pc)] with valid=1, new tag, update_target, update_is_cond. Overwrites any aliasing entry (direct mapped, no replacement policy).
  - If update_is_cond: PHT[p_idx(update_pc)] increments on taken, decrements on not-taken, saturating at 3/0. The GHR value used is the one before this cycle's shift.
  - Not-taken conditional: BTB untouched; an existing entry is kept.
  - Non-conditional: PHT untouched.
  - update_is_cond=0 with update_taken=0 is illegal; the block ignores it entirely.
- Same-cycle read and write to the same entry: prediction uses the old state (no bypass). The new state is visible the next cycle.
- Reset:
  - All valid=0, all counters=WNT (1), ghr=0.
  - pred_taken=0 and pred_next_pc=if_pc+4 while reset is high and after it.
  - Reset mid-operation discards all training; any update asserted in the same cycle is dropped.

Optional Feature:
- Macro BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - GHR_BITS-wide global history register.
  - On each conditional update: ghr <= {ghr[GHR_BITS-2:0], update_taken}.
  - PHT indexed by idx XOR ghr.
- Undefined: no GHR register; bimodal PHT indexed by idx. GHR_BITS is unused.

Decomposition:
- Shared package bp_pkg:
  - Counter encoding constants SNT/WNT/WT/ST.
  - Reset counter value WNT.
  - Function computing IDX from ENTRIES.
  - Typedef for a BTB entry struct.
- One sub-module, pht_table: counter array with saturating update, read index, write index, reset-to-WNT.

Test Plan (ENTRIES=32, macro undefined unless stated):
1. After reset, if_pc=0x40 -> pred_taken=0, pred_target=0, pred_next_pc=0x44.
2. One cond update pc=0x40, taken, target=0x10 -> counter 1->2; next cycle if_pc=0x40 gives pred_taken=1, pred_next_pc=0x10. In the update cycle itself, if_pc=0x40 still gives pred_taken=0.
3. Two further not-taken updates at 0x40 -> counter 2->1->0; pred_taken=0, pred_target=0x10 (entry kept), pred_next_pc=0x44. Then four taken updates -> counter saturates at 3; one not-taken -> 2, still predicts taken.
4. JAL update pc=0xC0 (aliases idx 16 with 0x40), target=0x200 -> if_pc=0x40 misses, next=0x44; if_pc=0xC0 gives pred_taken=1 regardless of counter, next=0x200.
5. Train 0x40 taken, then assert reset for 1 cycle -> if_pc=0x40 gives pred_taken=0, next=0x44; an update asserted during reset is lost.
6. With BRANCH_PREDICTOR_GSHARE_EN, GHR_BITS=5:
   - Cond taken updates at 0x40 three times -> ghr=5'b00111.
   - The three updates train PHT indices 16, 17 and 19 from WNT to WT.
   - Prediction for 0x40 now uses index 16^7=23 (still WNT), so pred_taken=0 and next=0x44.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB + PHT next-PC predictor.
// Counter encoding, reset counter value and index-width helper.
package bp_pkg;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   localparam logic [1:0] CNT_RST = WNT;

   // Width-independent part of a BTB entry; tag/target widths are
   // fixed by the instantiating module's parameters.
   typedef struct packed {
      logic valid;
      logic is_cond;
   } btb_ctrl_t;

   function automatic int unsigned idx_width(input int unsigned entries);
      return $clog2(entries);
   endfunction

endpackage

// File: rtl/branch_predictor_pht_table.sv
// Pattern history table: 2-bit saturating counters, one read port,
// one write port, synchronous reset of every counter to WNT.
module pht_table
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 32,
   localparam int unsigned IDX_W = idx_width(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   logic [1:0] cnt_q [ENTRIES];
   logic [1:0] cnt_d [ENTRIES];
   logic [1:0] wr_cur;

   assign rd_cnt = cnt_q[rd_idx];
   assign wr_cur = cnt_q[wr_idx];

   always_comb begin
      cnt_d = cnt_q;
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_d[i] = CNT_RST;
         end
      end else if (wr_en) begin
         if (wr_taken && wr_cur != ST) begin
            cnt_d[wr_idx] = wr_cur + 2'd1;
         end else if (!wr_taken && wr_cur != SNT) begin
            cnt_d[wr_idx] = wr_cur - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage next-PC predictor: direct-mapped BTB plus 2-bit PHT.
// Define BRANCH_PREDICTOR_GSHARE_EN for a gshare-indexed PHT.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ENTRIES  = 32,
   parameter int unsigned GHR_BITS = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic [XLEN-1:0] pred_next_pc,
   input  logic            update_valid,
   input  logic [XLEN-1:0] update_pc,
   input  logic            update_is_cond,
   input  logic            update_taken,
   input  logic [XLEN-1:0] update_target
);

   localparam int unsigned IDX_W = idx_width(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   typedef struct packed {
      btb_ctrl_t         ctrl;
      logic [TAG_W-1:0]  tag;
      logic [XLEN-1:0]   target;
   } btb_entry_t;

   btb_entry_t btb_q [ENTRIES];
   btb_entry_t btb_d [ENTRIES];
   btb_entry_t rd_ent;

   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_pidx;
   logic [IDX_W-1:0] wr_pidx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic [1:0]       pht_cnt;
   logic             hit;
   logic             pht_wr;
   logic             unused_ok;

   assign rd_idx = if_pc[IDX_W+1:2];
   assign rd_tag = if_pc[XLEN-1:IDX_W+2];
   assign wr_idx = update_pc[IDX_W+1:2];
   assign wr_tag = update_pc[XLEN-1:IDX_W+2];

   assign pht_wr = update_valid && update_is_cond && !reset;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   always_comb begin
      ghr_d = ghr_q;
      if (reset) begin
         ghr_d = '0;
      end else if (update_valid && update_is_cond) begin
         ghr_d = {ghr_q[GHR_BITS-2:0], update_taken};
      end
   end

   always_ff @(posedge clk) begin
      ghr_q <= ghr_d;
   end

   // Write index uses the history before this cycle's shift.
   assign rd_pidx   = rd_idx ^ IDX_W'(ghr_q);
   assign wr_pidx   = wr_idx ^ IDX_W'(ghr_q);
   assign unused_ok = ^{if_pc[1:0], update_pc[1:0]};
`else
   assign rd_pidx   = rd_idx;
   assign wr_pidx   = wr_idx;
   assign unused_ok = ^{if_pc[1:0], update_pc[1:0], 1'(GHR_BITS)};
`endif

   pht_table #(
      .ENTRIES (ENTRIES)
   ) u_pht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (rd_pidx),
      .rd_cnt   (pht_cnt),
      .wr_en    (pht_wr),
      .wr_idx   (wr_pidx),
      .wr_taken (update_taken)
   );

   assign rd_ent = btb_q[rd_idx];
   assign hit    = rd_ent.ctrl.valid && (rd_ent.tag == rd_tag);

   assign pred_taken   = !reset && hit &&
                         (!rd_ent.ctrl.is_cond || pht_cnt >= WT);
   assign pred_target  = hit ? rd_ent.target : '0;
   assign pred_next_pc = pred_taken ? pred_target : if_pc + XLEN'(4);

   // Only taken control flow allocates; the illegal not-taken
   // unconditional update therefore touches nothing.
   always_comb begin
      btb_d = btb_q;
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            btb_d[i].ctrl.valid = 1'b0;
         end
      end else if (update_valid && update_taken) begin
         btb_d[wr_idx].ctrl.valid   = 1'b1;
         btb_d[wr_idx].ctrl.is_cond = update_is_cond;
         btb_d[wr_idx].tag          = wr_tag;
         btb_d[wr_idx].target       = update_target;
      end
   end

   always_ff @(posedge clk) begin
      btb_q <= btb_d;
   end

endmodule
